// File: rtl/jstk_pkg.sv
// Shared constants, FSM state type and tx byte packing for the PmodJSTK2 SPI responder.
package jstk_pkg;

  localparam logic [7:0] CMD_SET_LED  = 8'h84;
  localparam logic [7:0] CMD_GET_DATA = 8'hC0;
  localparam int         FRAME_BYTES  = 5;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Byte k of the reply frame lives at index k.
  function automatic logic [FRAME_BYTES-1:0][7:0] pack_tx(
    input logic [9:0] x,
    input logic [9:0] y,
    input logic [1:0] b
  );
    pack_tx[0] = x[7:0];
    pack_tx[1] = {6'b0, x[9:8]};
    pack_tx[2] = y[7:0];
    pack_tx[3] = {6'b0, y[9:8]};
    pack_tx[4] = {6'b0, b};
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with a trailing edge-detect flop producing rise/fall pulses.
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign dout = sync_q[STAGES-1];
  assign rise = dout & ~prev_q;
  assign fall = ~dout & prev_q;

endmodule

// File: rtl/jstk2_spi_responder.sv
// SPI mode-0 slave emulating the PmodJSTK2: returns position/buttons, decodes the RGB LED command.
// Optional JSTK_RSP_TRISTATE_EN: MISO floats while the slave is not selected.
module jstk2_spi_responder
  import jstk_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  xpos,
  input  logic [9:0]  ypos,
  input  logic [1:0]  button,
  input  logic        SS,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic [7:0]  cmd,
  output logic [23:0] rgb,
  output logic        rgb_valid,
  output logic        frame_done,
  output logic        busy,
  output state_t      dbg_state
);

  logic sclk_unused, sclk_rise, sclk_fall;
  logic ss_level, ss_rise, ss_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic mosi_s;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rst(rst), .din(SCLK),
    .dout(sclk_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
    .clk(clk), .rst(rst), .din(SS),
    .dout(ss_level), .rise(ss_rise), .fall(ss_fall)
  );

  // MOSI is only sampled on SCLK rise, so it needs no extra edge flop to stay aligned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mosi_sync <= '0;
    else      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
  end
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // The SS synchronizer resets high, so a low SS at reset release looks like a fall.
  // Frames are armed only once the chain has flushed and SS has really been seen high.
  logic [SYNC_STAGES:0] settle_q;
  logic                 armed;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      settle_q <= '0;
      armed    <= 1'b0;
    end else begin
      settle_q <= {settle_q[SYNC_STAGES-1:0], 1'b1};
      if (settle_q[SYNC_STAGES] && ss_level) armed <= 1'b1;
    end
  end

  state_t state, state_next;
  logic   frame_start, frame_end;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next  = state;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    case (state)
      IDLE: if (ss_fall && armed) begin
        state_next  = ACTIVE;
        frame_start = 1'b1;
      end
      ACTIVE: if (ss_rise) begin
        state_next = IDLE;
        frame_end  = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  logic [FRAME_BYTES-1:0][7:0] snap, tx_buf;
  logic [3:0][7:0]             rx;
  logic [7:0]                  tx_shift, rx_shift, rx_byte, next_tx;
  logic [2:0]                  byte_idx;
  logic [3:0]                  bit_cnt, bit_cnt_inc;

  assign snap        = pack_tx(xpos, ypos, button);
  assign rx_byte     = {rx_shift[6:0], mosi_s};
  assign bit_cnt_inc = bit_cnt + 4'd1;

  always_comb begin
    next_tx = 8'h00;
    if (int'(byte_idx) < FRAME_BYTES) next_tx = tx_buf[byte_idx];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_buf     <= '0;
      rx         <= '0;
      tx_shift   <= 8'h00;
      rx_shift   <= 8'h00;
      byte_idx   <= 3'd0;
      bit_cnt    <= 4'd0;
      cmd        <= 8'h00;
      rgb        <= 24'h000000;
      rgb_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      rgb_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (frame_start) begin
        tx_buf   <= snap;
        tx_shift <= snap[0];
        rx_shift <= 8'h00;
        byte_idx <= 3'd0;
        bit_cnt  <= 4'd0;
      end else if (frame_end) begin
        if (byte_idx != 3'd0) begin
          cmd        <= rx[0];
          frame_done <= 1'b1;
        end
        if (byte_idx >= 3'd4 && rx[0] == CMD_SET_LED) begin
          rgb       <= {rx[1], rx[2], rx[3]};
          rgb_valid <= 1'b1;
        end
      end else if (state == ACTIVE) begin
        if (sclk_rise) begin
          rx_shift <= rx_byte;
          if (bit_cnt_inc == 4'd8) begin
            if (byte_idx < 3'd4) rx[byte_idx[1:0]] <= rx_byte;
            if (byte_idx != 3'd7) byte_idx <= byte_idx + 3'd1;
            bit_cnt <= 4'd0;
          end else begin
            bit_cnt <= bit_cnt_inc;
          end
        end else if (sclk_fall) begin
          // bit_cnt==0 here means a byte just completed: present the next byte's MSB.
          if (bit_cnt == 4'd0) tx_shift <= next_tx;
          else                 tx_shift <= {tx_shift[6:0], 1'b0};
        end
      end
    end
  end

  assign busy      = (state == ACTIVE);
  assign dbg_state = state;

`ifdef JSTK_RSP_TRISTATE_EN
  assign MISO = busy ? tx_shift[7] : 1'bz;
`else
  assign MISO = busy ? tx_shift[7] : 1'b0;
`endif

endmodule

// File: tb/tb_jstk2_spi_responder.sv
// Bench for jstk2_spi_responder: SPI master driver, frame-level reference model, scoreboard monitor.
module tb_jstk2_spi_responder;
  import jstk_pkg::*;

  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  xpos = '0, ypos = '0;
  logic [1:0]  button = '0;
  logic        SS = 1'b1, SCLK = 1'b0, MOSI = 1'b0;
  logic        MISO;
  logic [7:0]  cmd;
  logic [23:0] rgb;
  logic        rgb_valid, frame_done, busy;
  state_t      dbg_state;

  jstk2_spi_responder #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .xpos(xpos), .ypos(ypos), .button(button),
    .SS(SS), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .cmd(cmd), .rgb(rgb), .rgb_valid(rgb_valid), .frame_done(frame_done),
    .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Expected frame-end results: {rgb_valid, cmd, rgb}.
  logic [32:0] exp_q[$];
  logic [7:0]  m_cmd = 8'h00;
  logic [23:0] m_rgb = 24'h000000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    logic miso_exp;
`ifdef JSTK_RSP_TRISTATE_EN
    miso_exp = 1'bz;
`else
    miso_exp = 1'b0;
`endif
    chk({tag, "_cmd"}, {24'h0, cmd}, 32'h0);
    chk({tag, "_rgb"}, {8'h0, rgb}, 32'h0);
    chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
    chk({tag, "_frame_done"}, {31'h0, frame_done}, 32'h0);
    chk({tag, "_rgb_valid"}, {31'h0, rgb_valid}, 32'h0);
    checks++;
    if (MISO !== miso_exp) begin
      failures++;
      $display("FAIL %s_miso actual=%b required=%b", tag, MISO, miso_exp);
    end
  endtask

  // Monitor: every frame_done pops one expectation; pulses must be single-cycle.
  logic pulse_seen = 1'b0;
  always @(negedge clk) begin
    if (pulse_seen) begin
      checks++;
      if (frame_done || rgb_valid) begin
        failures++;
        $display("FAIL pulse_width frame_done=%b rgb_valid=%b required=0", frame_done, rgb_valid);
      end
    end
    pulse_seen <= frame_done || rgb_valid;
    if (frame_done) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_frame_done cmd=%0h required=no frame", cmd);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("frame_cmd", {24'h0, cmd}, {24'h0, e[31:24]});
        chk("frame_rgb", {8'h0, rgb}, {8'h0, e[23:0]});
        chk("frame_rgb_valid", {31'h0, rgb_valid}, {31'h0, e[32]});
      end
    end else if (rgb_valid) begin
      checks++;
      failures++;
      $display("FAIL rgb_valid_without_frame_done actual=1 required=0");
    end
  end

  // Master frame: nbytes whole bytes then extra_bits of a partial byte; optionally moves xpos mid-frame.
  task automatic spi_frame(input logic [7:0] bytes[8], input int nbytes, input int extra_bits,
                           input int chg_after, input logic [9:0] chg_x);
    logic [7:0] exp_rd[8];
    logic [7:0] got;
    int         total, nb;
    bit         led;
    for (int i = 0; i < 8; i++) exp_rd[i] = 8'h00;
    exp_rd[0] = 8'(xpos % 256);
    exp_rd[1] = 8'(xpos / 256);
    exp_rd[2] = 8'(ypos % 256);
    exp_rd[3] = 8'(ypos / 256);
    exp_rd[4] = 8'(button);
    if (nbytes >= 1) begin
      led = (nbytes >= 4) && (bytes[0] == CMD_SET_LED);
      m_cmd = bytes[0];
      if (led) m_rgb = {bytes[1], bytes[2], bytes[3]};
      exp_q.push_back({led, m_cmd, m_rgb});
    end
    total = nbytes + ((extra_bits > 0) ? 1 : 0);
    @(negedge clk) SS = 1'b0;
    repeat (HALF) @(negedge clk);
    chk("busy_in_frame", {31'h0, busy}, 32'h1);
    for (int b = 0; b < total; b++) begin
      nb = (b < nbytes) ? 8 : extra_bits;
      got = 8'h00;
      for (int k = 0; k < nb; k++) begin
        MOSI = bytes[b][7-k];
        repeat (HALF) @(negedge clk);
        got = {got[6:0], MISO};
        SCLK = 1'b1;
        repeat (HALF) @(negedge clk);
        SCLK = 1'b0;
      end
      if (b < nbytes) chk($sformatf("miso_byte%0d", b), {24'h0, got}, {24'h0, exp_rd[b]});
      if (b == chg_after) xpos = chg_x;
    end
    repeat (HALF) @(negedge clk);
    SS = 1'b1;
    repeat (4 * HALF) @(negedge clk);
  endtask

  logic [7:0] fb[8];

  task automatic set_fb(input logic [63:0] v);
    for (int i = 0; i < 8; i++) fb[i] = v[63-8*i -: 8];
  endtask

  initial begin
    repeat (4) @(negedge clk);
    chk_reset_values("reset");
    rst = 1'b1;
    repeat (10) @(negedge clk);

    // LED command frame
    xpos = 10'h2AB; ypos = 10'h155; button = 2'b10;
    set_fb(64'h84FF800100000000);
    spi_frame(fb, 5, 0, -1, 10'h0);
    chk("rgb_after_led", {8'h0, rgb}, 32'hFF8001);

    // Get-data frame leaves rgb alone
    set_fb(64'hC011223300000000);
    spi_frame(fb, 5, 0, -1, 10'h0);
    chk("rgb_after_get", {8'h0, rgb}, 32'hFF8001);

    // xpos moves mid-frame: snapshot holds, next frame sees it
    xpos = 10'h000;
    set_fb(64'hC000000000000000);
    spi_frame(fb, 5, 0, 1, 10'h3FF);
    spi_frame(fb, 5, 0, -1, 10'h0);

    // 2.5-byte LED frame, then a normal one
    set_fb(64'h84AABBCC00000000);
    spi_frame(fb, 2, 4, -1, 10'h0);
    set_fb(64'h8412345600000000);
    spi_frame(fb, 5, 0, -1, 10'h0);

    // 7-byte frame: trailing bytes read zero
    set_fb(64'h8401020304050600);
    spi_frame(fb, 7, 0, -1, 10'h0);

    // Reset mid-frame with SS held low
    @(negedge clk) SS = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      SCLK = 1'b1; repeat (HALF) @(negedge clk);
      SCLK = 1'b0; repeat (HALF) @(negedge clk);
    end
    rst = 1'b0;
    m_cmd = 8'h00;
    m_rgb = 24'h000000;
    repeat (3) @(negedge clk);
    chk_reset_values("midframe_reset");
    rst = 1'b1;
    for (int k = 0; k < 16; k++) begin
      MOSI = 1'($urandom_range(0, 1));
      SCLK = 1'b1; repeat (HALF) @(negedge clk);
      SCLK = 1'b0; repeat (HALF) @(negedge clk);
    end
    chk("busy_after_reset_ss_low", {31'h0, busy}, 32'h0);
    chk("state_after_reset_ss_low", {31'h0, dbg_state == ACTIVE}, 32'h0);
    SS = 1'b1;
    repeat (4 * HALF) @(negedge clk);
    chk("cmd_still_reset", {24'h0, cmd}, 32'h0);
    set_fb(64'h849A7B3C00000000);
    spi_frame(fb, 5, 0, -1, 10'h0);

    // Randomized frames
    for (int n = 0; n < 10; n++) begin
      int sel;
      xpos = 10'($urandom_range(0, 1023));
      ypos = 10'($urandom_range(0, 1023));
      button = 2'($urandom_range(0, 3));
      for (int i = 0; i < 8; i++) fb[i] = 8'($urandom_range(0, 255));
      sel = $urandom_range(0, 2);
      if (sel == 0) fb[0] = CMD_SET_LED;
      else if (sel == 1) fb[0] = CMD_GET_DATA;
      spi_frame(fb, $urandom_range(0, 7), $urandom_range(0, 7), -1, 10'h0);
    end

    for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(negedge clk);
    chk("scoreboard_drain", exp_q.size(), 32'h0);
    chk("final_rgb", {8'h0, rgb}, {8'h0, m_rgb});
    chk("final_cmd", {24'h0, cmd}, {24'h0, m_cmd});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
